// File: rtl/prf_read_arbiter_pkg.sv
// Shared types and constants for the PRF read-port arbiter.
//   FU_NUM     : number of FU issue slots competing for read ports
//   PHYS_W     : physical register index width
//   PRF_RP_NUM : number of physical PRF read-port pairs (rs1 + rs2)
//   prf_rsp_t  : one-entry response buffer contents per FU
//   wb_hit     : CDB wakeup match against a physical source index
package prf_read_arbiter_pkg;

    localparam int FU_NUM     = 4;
    localparam int PHYS_W     = 6;
    localparam int PRF_RP_NUM = 2;

    typedef struct packed {
        logic [31:0]       rdata1;
        logic [31:0]       rdata2;
        logic              rready1;
        logic              rready2;
        logic [PHYS_W-1:0] prs1;
        logic [PHYS_W-1:0] prs2;
    } prf_rsp_t;

    // p0 is the hardwired zero register; a wakeup naming it never carries
    // meaningful data, so it must not overwrite a buffered operand.
    function automatic logic wb_hit(input logic              wb_valid,
                                    input logic [PHYS_W-1:0] wb_pd,
                                    input logic [PHYS_W-1:0] prs);
        return wb_valid && (wb_pd == prs) && (wb_pd != '0);
    endfunction

endpackage

// File: rtl/prf_read_arbiter_rr_multi_grant.sv
// Combinational rotating-priority picker that grants up to RP_NUM of FU_NUM
// requesters per cycle, scanning from ptr upward with wrap.
//   req        : request mask
//   ptr        : index with highest priority this cycle
//   grant      : granted mask
//   port_idx   : per requester, the port pair it owns (valid where granted)
//   port_used  : per port pair, whether it has an owner
//   port_owner : per port pair, the index of its owner
//   any_grant  : at least one grant issued
//   next_ptr   : one past the last granted index in scan order, modulo FU_NUM
module rr_multi_grant
    import prf_read_arbiter_pkg::*;
#(
    parameter int FU_NUM = prf_read_arbiter_pkg::FU_NUM,
    parameter int RP_NUM = PRF_RP_NUM,
    localparam int IW = (FU_NUM > 1) ? $clog2(FU_NUM) : 1,
    localparam int PW = (RP_NUM > 1) ? $clog2(RP_NUM) : 1
) (
    input  logic [FU_NUM-1:0]         req,
    input  logic [IW-1:0]             ptr,
    output logic [FU_NUM-1:0]         grant,
    output logic [FU_NUM-1:0][PW-1:0] port_idx,
    output logic [RP_NUM-1:0]         port_used,
    output logic [RP_NUM-1:0][IW-1:0] port_owner,
    output logic                      any_grant,
    output logic [IW-1:0]             next_ptr
);

    localparam logic [PW:0] RP_MAX = (PW + 1)'(RP_NUM);

    logic [PW:0]   cnt;
    logic [IW-1:0] idx;
    logic [IW-1:0] last;

    always_comb begin
        grant      = '0;
        port_idx   = '0;
        port_used  = '0;
        port_owner = '0;
        cnt        = '0;
        idx        = '0;
        last       = '0;
        for (int j = 0; j < FU_NUM; j++) begin
            idx = IW'((int'(ptr) + j) % FU_NUM);
            if (req[idx] && (cnt < RP_MAX)) begin
                grant[idx]               = 1'b1;
                port_idx[idx]            = cnt[PW-1:0];
                port_used[cnt[PW-1:0]]   = 1'b1;
                port_owner[cnt[PW-1:0]]  = idx;
                last                     = idx;
                cnt                      = cnt + 1'b1;
            end
        end
        any_grant = |grant;
        next_ptr  = (last == IW'(FU_NUM - 1)) ? '0 : last + 1'b1;
    end

endmodule

// File: rtl/prf_read_arbiter.sv
// Shares RP_NUM PRF read-port pairs among FU_NUM issue slots. Grants are
// round-robin; granted operands are registered into a one-entry response
// buffer per FU, which snoops the CDB so not-ready operands wake up.
//   clk, rst_n                 : clock, synchronous active-low reset
//   req_valid/ready/prs1/prs2  : per-FU operand read request, grant
//   rsp_valid/ready            : per-FU response handshake
//   rsp_rdata1/2, rsp_rready1/2: buffered operand values and ready bits
//   prf_raddr1/2               : per-port-pair PRF read addresses
//   prf_rdata1/2, prf_rready1/2: combinational PRF read data and ready bits
//   wb_valid/pd/data           : CDB wakeup
//   flush_valid, recover_valid : kill all grants and responses
module prf_read_arbiter
    import prf_read_arbiter_pkg::*;
#(
    parameter int FU_NUM = prf_read_arbiter_pkg::FU_NUM,
    parameter int RP_NUM = PRF_RP_NUM,
    localparam int IW = (FU_NUM > 1) ? $clog2(FU_NUM) : 1,
    localparam int PW = (RP_NUM > 1) ? $clog2(RP_NUM) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [FU_NUM-1:0]               req_valid,
    output logic [FU_NUM-1:0]               req_ready,
    input  logic [FU_NUM-1:0][PHYS_W-1:0]   req_prs1,
    input  logic [FU_NUM-1:0][PHYS_W-1:0]   req_prs2,
    output logic [FU_NUM-1:0]               rsp_valid,
    input  logic [FU_NUM-1:0]               rsp_ready,
    output logic [FU_NUM-1:0][31:0]         rsp_rdata1,
    output logic [FU_NUM-1:0][31:0]         rsp_rdata2,
    output logic [FU_NUM-1:0]               rsp_rready1,
    output logic [FU_NUM-1:0]               rsp_rready2,
    output logic [RP_NUM-1:0][PHYS_W-1:0]   prf_raddr1,
    output logic [RP_NUM-1:0][PHYS_W-1:0]   prf_raddr2,
    input  logic [RP_NUM-1:0][31:0]         prf_rdata1,
    input  logic [RP_NUM-1:0][31:0]         prf_rdata2,
    input  logic [RP_NUM-1:0]               prf_rready1,
    input  logic [RP_NUM-1:0]               prf_rready2,
    input  logic                            wb_valid,
    input  logic [PHYS_W-1:0]               wb_pd,
    input  logic [31:0]                     wb_data,
    input  logic                            flush_valid,
    input  logic                            recover_valid
);

    logic                      kill;
    logic [FU_NUM-1:0]         elig;
    logic [FU_NUM-1:0]         grant;
    logic [FU_NUM-1:0][PW-1:0] port_idx;
    logic [RP_NUM-1:0]         port_used;
    logic [RP_NUM-1:0][IW-1:0] port_owner;
    logic                      any_grant;
    logic [IW-1:0]             next_ptr;
    logic [IW-1:0]             rr_ptr;

    prf_rsp_t rsp_buf [FU_NUM];
    prf_rsp_t cap     [FU_NUM];
    prf_rsp_t upd     [FU_NUM];

    assign kill = flush_valid | recover_valid;

    // A full buffer only frees up for a new grant if it is popped this cycle.
    assign elig = req_valid & (~rsp_valid | rsp_ready) & {FU_NUM{~kill}};

    rr_multi_grant #(
        .FU_NUM (FU_NUM),
        .RP_NUM (RP_NUM)
    ) u_pick (
        .req        (elig),
        .ptr        (rr_ptr),
        .grant      (grant),
        .port_idx   (port_idx),
        .port_used  (port_used),
        .port_owner (port_owner),
        .any_grant  (any_grant),
        .next_ptr   (next_ptr)
    );

    assign req_ready = grant;

    always_comb begin
        for (int k = 0; k < RP_NUM; k++) begin
            prf_raddr1[k] = port_used[k] ? req_prs1[port_owner[k]] : '0;
            prf_raddr2[k] = port_used[k] ? req_prs2[port_owner[k]] : '0;
        end
    end

    // cap: what a granted FU would latch (PRF data, or same-cycle CDB bypass
    // when the PRF says not-ready). upd: held buffer after CDB snoop.
    always_comb begin
        for (int i = 0; i < FU_NUM; i++) begin
            cap[i]      = '0;
            cap[i].prs1 = req_prs1[i];
            cap[i].prs2 = req_prs2[i];
            if (!prf_rready1[port_idx[i]] && wb_hit(wb_valid, wb_pd, req_prs1[i])) begin
                cap[i].rdata1  = wb_data;
                cap[i].rready1 = 1'b1;
            end else begin
                cap[i].rdata1  = prf_rdata1[port_idx[i]];
                cap[i].rready1 = prf_rready1[port_idx[i]];
            end
            if (!prf_rready2[port_idx[i]] && wb_hit(wb_valid, wb_pd, req_prs2[i])) begin
                cap[i].rdata2  = wb_data;
                cap[i].rready2 = 1'b1;
            end else begin
                cap[i].rdata2  = prf_rdata2[port_idx[i]];
                cap[i].rready2 = prf_rready2[port_idx[i]];
            end

            upd[i] = rsp_buf[i];
            if (!rsp_buf[i].rready1 && wb_hit(wb_valid, wb_pd, rsp_buf[i].prs1)) begin
                upd[i].rdata1  = wb_data;
                upd[i].rready1 = 1'b1;
            end
            if (!rsp_buf[i].rready2 && wb_hit(wb_valid, wb_pd, rsp_buf[i].prs2)) begin
                upd[i].rdata2  = wb_data;
                upd[i].rready2 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rr_ptr    <= '0;
            for (int i = 0; i < FU_NUM; i++) begin
                rsp_buf[i] <= '0;
            end
        end else begin
            // kill suppresses all grants, so it never moves the pointer
            if (any_grant) begin
                rr_ptr <= next_ptr;
            end
            for (int i = 0; i < FU_NUM; i++) begin
                if (kill) begin
                    rsp_valid[i] <= 1'b0;
                end else if (grant[i]) begin
                    rsp_valid[i] <= 1'b1;
                    rsp_buf[i]   <= cap[i];
                end else if (rsp_valid[i] && rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end else if (rsp_valid[i]) begin
                    rsp_buf[i]   <= upd[i];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < FU_NUM; i++) begin
            rsp_rdata1[i]  = rsp_buf[i].rdata1;
            rsp_rdata2[i]  = rsp_buf[i].rdata2;
            rsp_rready1[i] = rsp_buf[i].rready1;
            rsp_rready2[i] = rsp_buf[i].rready2;
        end
    end

endmodule

// File: tb/tb_prf_read_arbiter.sv
// Self-checking bench for prf_read_arbiter (FU_NUM=4, RP_NUM=2): a constant
// table of handshake vectors, hand-written multi-cycle corner cases, and a
// randomized run checked against a queue-based reference model.
module tb_prf_read_arbiter;
    import prf_read_arbiter_pkg::*;

    localparam int FU = 4;
    localparam int RP = 2;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [FU-1:0]              req_valid;
    logic [FU-1:0]              req_ready;
    logic [FU-1:0][PHYS_W-1:0]  req_prs1;
    logic [FU-1:0][PHYS_W-1:0]  req_prs2;
    logic [FU-1:0]              rsp_valid;
    logic [FU-1:0]              rsp_ready;
    logic [FU-1:0][31:0]        rsp_rdata1;
    logic [FU-1:0][31:0]        rsp_rdata2;
    logic [FU-1:0]              rsp_rready1;
    logic [FU-1:0]              rsp_rready2;
    logic [RP-1:0][PHYS_W-1:0]  prf_raddr1;
    logic [RP-1:0][PHYS_W-1:0]  prf_raddr2;
    logic [RP-1:0][31:0]        prf_rdata1;
    logic [RP-1:0][31:0]        prf_rdata2;
    logic [RP-1:0]              prf_rready1;
    logic [RP-1:0]              prf_rready2;
    logic                       wb_valid;
    logic [PHYS_W-1:0]          wb_pd;
    logic [31:0]                wb_data;
    logic                       flush_valid;
    logic                       recover_valid;

    int vectors     = 0;
    int miscompares = 0;

    prf_read_arbiter #(.FU_NUM(FU), .RP_NUM(RP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_prs1      (req_prs1),
        .req_prs2      (req_prs2),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata1    (rsp_rdata1),
        .rsp_rdata2    (rsp_rdata2),
        .rsp_rready1   (rsp_rready1),
        .rsp_rready2   (rsp_rready2),
        .prf_raddr1    (prf_raddr1),
        .prf_raddr2    (prf_raddr2),
        .prf_rdata1    (prf_rdata1),
        .prf_rdata2    (prf_rdata2),
        .prf_rready1   (prf_rready1),
        .prf_rready2   (prf_rready2),
        .wb_valid      (wb_valid),
        .wb_pd         (wb_pd),
        .wb_data       (wb_data),
        .flush_valid   (flush_valid),
        .recover_valid (recover_valid)
    );

    always #5 clk = ~clk;

    // Register file contents seen by the read ports.
    logic [31:0] prf_d [64];
    bit          prf_r [64];

    always_comb begin
        for (int k = 0; k < RP; k++) begin
            prf_rdata1[k]  = prf_d[prf_raddr1[k]];
            prf_rdata2[k]  = prf_d[prf_raddr2[k]];
            prf_rready1[k] = prf_r[prf_raddr1[k]];
            prf_rready2[k] = prf_r[prf_raddr2[k]];
        end
    end

    // Reference model state.
    int          m_ptr;
    bit          m_valid [FU];
    logic [31:0] m_d1 [FU];
    logic [31:0] m_d2 [FU];
    bit          m_r1 [FU];
    bit          m_r2 [FU];
    logic [5:0]  m_p1 [FU];
    logic [5:0]  m_p2 [FU];

    typedef struct {
        logic [3:0] rv;
        logic [3:0] rr;
        logic       fl;
        logic       rc;
        logic [3:0] e_rdy;
        logic [3:0] e_val;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic clear_inputs();
        req_valid     = '0;
        req_prs1      = '0;
        req_prs2      = '0;
        rsp_ready     = '1;
        wb_valid      = 1'b0;
        wb_pd         = '0;
        wb_data       = '0;
        flush_valid   = 1'b0;
        recover_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        for (int i = 0; i < FU; i++) begin
            m_valid[i] = 0; m_d1[i] = '0; m_d2[i] = '0;
            m_r1[i] = 0; m_r2[i] = 0; m_p1[i] = '0; m_p2[i] = '0;
        end
    endtask

    function automatic bit m_hit(input logic [5:0] pd);
        return wb_valid && (wb_pd == pd) && (pd != 6'd0);
    endfunction

    // One random cycle: predict outputs, compare, then advance the model.
    task automatic model_cycle();
        int          q[$];
        logic [3:0]  exp_gr;
        logic [3:0]  exp_val;
        bit          kill;
        bit          h;
        logic [5:0]  p;
        kill   = flush_valid || recover_valid;
        exp_gr = '0;
        for (int j = 0; j < FU; j++) begin
            int i;
            i = (m_ptr + j) % FU;
            if (!kill && req_valid[i] && (!m_valid[i] || rsp_ready[i]) && q.size() < RP) begin
                q.push_back(i);
                exp_gr[i] = 1'b1;
            end
        end
        check("req_ready", 64'(req_ready), 64'(exp_gr));
        for (int k = 0; k < RP; k++) begin
            check($sformatf("prf_raddr1[%0d]", k), 64'(prf_raddr1[k]),
                  (k < q.size()) ? 64'(req_prs1[q[k]]) : 64'd0);
            check($sformatf("prf_raddr2[%0d]", k), 64'(prf_raddr2[k]),
                  (k < q.size()) ? 64'(req_prs2[q[k]]) : 64'd0);
        end
        exp_val = '0;
        for (int i = 0; i < FU; i++) exp_val[i] = m_valid[i];
        check("rsp_valid", 64'(rsp_valid), 64'(exp_val));
        for (int i = 0; i < FU; i++) begin
            if (m_valid[i]) begin
                check($sformatf("rdata1[%0d]", i), 64'(rsp_rdata1[i]), 64'(m_d1[i]));
                check($sformatf("rdata2[%0d]", i), 64'(rsp_rdata2[i]), 64'(m_d2[i]));
                check($sformatf("rready1[%0d]", i), 64'(rsp_rready1[i]), 64'(m_r1[i]));
                check($sformatf("rready2[%0d]", i), 64'(rsp_rready2[i]), 64'(m_r2[i]));
            end
        end
        for (int i = 0; i < FU; i++) begin
            if (kill) begin
                m_valid[i] = 0;
            end else if (exp_gr[i]) begin
                m_valid[i] = 1;
                p = req_prs1[i]; h = !prf_r[p] && m_hit(p);
                m_p1[i] = p; m_d1[i] = h ? wb_data : prf_d[p]; m_r1[i] = prf_r[p] || h;
                p = req_prs2[i]; h = !prf_r[p] && m_hit(p);
                m_p2[i] = p; m_d2[i] = h ? wb_data : prf_d[p]; m_r2[i] = prf_r[p] || h;
            end else if (m_valid[i] && rsp_ready[i]) begin
                m_valid[i] = 0;
            end else if (m_valid[i]) begin
                if (!m_r1[i] && m_hit(m_p1[i])) begin m_d1[i] = wb_data; m_r1[i] = 1; end
                if (!m_r2[i] && m_hit(m_p2[i])) begin m_d2[i] = wb_data; m_r2[i] = 1; end
            end
        end
        if (q.size() > 0) m_ptr = (q[q.size()-1] + 1) % FU;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        for (int r = 0; r < 64; r++) begin
            prf_d[r] = 32'h1000_0000 + 32'(r);
            prf_r[r] = 1'b1;
        end
        prf_d[0] = '0;

        //            rv       rr       fl rc  e_rdy    e_val
        tbl[0]  = '{4'b0000, 4'b1111, 0, 0, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b1111, 4'b1111, 0, 0, 4'b0011, 4'b0000};
        tbl[2]  = '{4'b1111, 4'b1111, 0, 0, 4'b1100, 4'b0011};
        tbl[3]  = '{4'b1111, 4'b1111, 0, 0, 4'b0011, 4'b1100};
        tbl[4]  = '{4'b1111, 4'b1111, 0, 0, 4'b1100, 4'b0011};
        tbl[5]  = '{4'b1111, 4'b1111, 1, 0, 4'b0000, 4'b1100};
        tbl[6]  = '{4'b0000, 4'b1111, 0, 0, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b0001, 4'b0000, 0, 0, 4'b0001, 4'b0000};
        tbl[8]  = '{4'b1111, 4'b1110, 0, 0, 4'b0110, 4'b0001};
        tbl[9]  = '{4'b1001, 4'b1111, 0, 0, 4'b1001, 4'b0111};
        tbl[10] = '{4'b0000, 4'b1111, 0, 0, 4'b0000, 4'b1001};
        tbl[11] = '{4'b0000, 4'b1111, 0, 0, 4'b0000, 4'b0000};
        tbl[12] = '{4'b1111, 4'b1111, 0, 1, 4'b0000, 4'b0000};
        tbl[13] = '{4'b1111, 4'b1111, 0, 0, 4'b0110, 4'b0000};

        do_reset();
        for (int v = 0; v < 14; v++) begin
            @(negedge clk);
            req_valid     = tbl[v].rv;
            rsp_ready     = tbl[v].rr;
            flush_valid   = tbl[v].fl;
            recover_valid = tbl[v].rc;
            #1;
            check($sformatf("tbl%0d req_ready", v), 64'(req_ready), 64'(tbl[v].e_rdy));
            check($sformatf("tbl%0d rsp_valid", v), 64'(rsp_valid), 64'(tbl[v].e_val));
        end

        // Single requester reads a ready register through port pair 0.
        do_reset();
        prf_d[5] = 32'hDEAD_BEEF; prf_r[5] = 1'b1;
        @(negedge clk);
        req_valid = 4'b0100; req_prs1[2] = 6'd5;
        #1;
        check("seqA req_ready", 64'(req_ready), 64'b0100);
        check("seqA raddr1[0]", 64'(prf_raddr1[0]), 64'd5);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("seqA rsp_valid", 64'(rsp_valid), 64'b0100);
        check("seqA rdata1[2]", 64'(rsp_rdata1[2]), 64'hDEAD_BEEF);
        check("seqA rready1[2]", 64'(rsp_rready1[2]), 64'd1);

        // Stalled response with a not-ready source wakes up from the CDB.
        do_reset();
        prf_d[9] = 32'h0000_0055; prf_r[9] = 1'b0;
        @(negedge clk);
        req_valid = 4'b0010; req_prs2[1] = 6'd9; rsp_ready = 4'b0000;
        @(negedge clk);
        req_valid = '0; wb_valid = 1'b1; wb_pd = 6'd9; wb_data = 32'h1234;
        #1;
        check("seqB rsp_valid", 64'(rsp_valid), 64'b0010);
        check("seqB rready2 before", 64'(rsp_rready2[1]), 64'd0);
        @(negedge clk);
        wb_valid = 1'b0;
        #1;
        check("seqB rdata2[1]", 64'(rsp_rdata2[1]), 64'h1234);
        check("seqB rready2[1]", 64'(rsp_rready2[1]), 64'd1);

        // Capture bypass: PRF not ready, same-cycle CDB write to that source.
        do_reset();
        prf_r[12] = 1'b0;
        @(negedge clk);
        req_valid = 4'b1000; req_prs1[3] = 6'd12;
        wb_valid = 1'b1; wb_pd = 6'd12; wb_data = 32'hCAFE_F00D;
        @(negedge clk);
        req_valid = '0; wb_valid = 1'b0;
        #1;
        check("seqC rdata1[3]", 64'(rsp_rdata1[3]), 64'hCAFE_F00D);
        check("seqC rready1[3]", 64'(rsp_rready1[3]), 64'd1);

        // Reset while responses are buffered discards them.
        do_reset();
        @(negedge clk);
        req_valid = 4'b1111; rsp_ready = 4'b0000;
        @(negedge clk);
        req_valid = '0; rst_n = 1'b0;
        #1;
        check("seqD rsp_valid pre", 64'(rsp_valid), 64'b0011);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("seqD rsp_valid post", 64'(rsp_valid), 64'b0000);

        // Randomized run against the reference model.
        for (int r = 1; r < 64; r++) begin
            prf_d[r] = $urandom;
            prf_r[r] = 1'($urandom_range(0, 1));
        end
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            req_valid     = 4'($urandom);
            rsp_ready     = 4'($urandom) | 4'($urandom);
            flush_valid   = ($urandom_range(0, 15) == 0);
            recover_valid = ($urandom_range(0, 31) == 0);
            wb_valid      = ($urandom_range(0, 2) == 0);
            wb_pd         = 6'($urandom_range(0, 15));
            wb_data       = $urandom;
            for (int i = 0; i < FU; i++) begin
                req_prs1[i] = 6'($urandom_range(0, 15));
                req_prs2[i] = 6'($urandom_range(0, 15));
            end
            #1;
            model_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prf_read_arbiter.md
Name: prf_read_arbiter

Overview:
- Shares a small number of physical PRF read-port pairs (rs1 + rs2) among the FU issue slots: ALU, BRU, LSU-store, LSU-load.
- Replaces the one-port-pair-per-FU wiring in the execute stage.
- Sits between the per-FU issue buffers and the PRF. Grants read ports round-robin and registers operands into a one-entry response buffer per FU.
- Snoops the CDB wakeup so a buffered operand that was not ready becomes ready.

Parameters:
- FU_NUM, 4, number of requesting FU slots.
- RP_NUM, 2, number of PRF read-port pairs; 1 <= RP_NUM <= FU_NUM.
- PHYS_W, package value, physical register index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  [FU_NUM]  FU i has an operand-read request.
- req_ready  out  [FU_NUM]  request i granted this cycle.
- req_prs1  in  PHYS_W x FU_NUM  source 1 physical index.
- req_prs2  in  PHYS_W x FU_NUM  source 2 physical index.
- rsp_valid  out  [FU_NUM]  operands for FU i available.
- rsp_ready  in  [FU_NUM]  FU i consumes its response.
- rsp_rdata1  out  32 x FU_NUM  source 1 value.
- rsp_rdata2  out  32 x FU_NUM  source 2 value.
- rsp_rready1  out  [FU_NUM]  source 1 ready bit.
- rsp_rready2  out  [FU_NUM]  source 2 ready bit.
- prf_raddr1  out  PHYS_W x RP_NUM  PRF read address, port pair k, source 1.
- prf_raddr2  out  PHYS_W x RP_NUM  PRF read address, port pair k, source 2.
- prf_rdata1  in  32 x RP_NUM  combinational read data, source 1.
- prf_rdata2  in  32 x RP_NUM  combinational read data, source 2.
- prf_rready1  in  [RP_NUM]  ready bit, source 1.
- prf_rready2  in  [RP_NUM]  ready bit, source 2.
- wb_valid  in  1  CDB wakeup valid (already qualified by uses_rd and data_valid).
- wb_pd  in  PHYS_W  CDB physical destination.
- wb_data  in  32  CDB result.
- flush_valid  in  1  kill all requests and responses.
- recover_valid  in  1  treated identically to flush_valid.

Behaviour:
- Reset (rst_n=0 at posedge):
  - rsp_valid=0, rr_ptr=0.
  - Buffered data, ready bits and prs indices cleared to 0.
- Eligibility, combinational:
  - elig[i] = req_valid[i] & (~rsp_valid[i] | rsp_ready[i]) & ~kill, where kill = flush_valid | recover_valid.
- Grant, combinational:
  - Scan indices rr_ptr, rr_ptr+1, ... mod FU_NUM.
  - The first up to RP_NUM eligible requesters are granted. The k-th grant in scan order owns port pair k.
  - req_ready[i] = granted[i].
  - prf_raddr1[k]/prf_raddr2[k] carry the owner's prs1/prs2; unowned ports drive 0.
- Round-robin pointer:
  - If any grant this cycle, rr_ptr <= (index of last granted + 1) mod FU_NUM; otherwise it holds.
  - Kill does not move rr_ptr.
- Capture at posedge for each granted i on port k:
  - rsp_valid[i] <= 1.
  - rdata1/rready1 <= prf_rdata1[k]/prf_rready1[k]; same for source 2.
  - prs1/prs2 are stored for snooping.
- Latency: grant in cycle N, rsp_valid in cycle N+1. Throughput is one response per FU per cycle when rsp_ready is held high.
- Same-cycle bypass at capture: if wb_valid and wb_pd == captured prs and PRF rready=0, capture wb_data with ready=1. A wb to prs 0 is ignored.
- Pop: rsp_valid[i] & rsp_ready[i] with no new grant gives rsp_valid[i] <= 0. Pop plus grant in the same cycle replaces the buffer.
- Snoop:
  - While rsp_valid[i] holds with rready1[i]=0 and wb_valid & wb_pd == prs1[i]: rdata1 <= wb_data, rready1 <= 1. Same for source 2.
  - Outputs reflect the update the cycle after the wb.
  - A snoop update is allowed while the response is stalled; it is not applied to a buffer being popped.
- Kill (flush_valid | recover_valid):
  - No grants that cycle.
  - All rsp_valid <= 0 at the next edge.
  - Outputs during the kill cycle are unchanged.
- Boundaries:
  - More than RP_NUM eligible: the rest wait, with no loss and no reordering per FU.
  - req_valid while its buffer is full and not popping: not eligible and not counted toward RP_NUM.
  - FU_NUM wrap of rr_ptr is covered by the modulo.
  - Reset asserted mid-transfer discards buffered responses.
- Width rules: indices compare at full PHYS_W. rr_ptr is $clog2(FU_NUM) bits.

Decomposition:
- Shared package (defines.svh):
  - FU_NUM, PHYS_W, new constant PRF_RP_NUM.
  - A prf_rsp_t struct {rdata1, rdata2, rready1, rready2, prs1, prs2}.
- Sub-module rr_multi_grant: combinational rotating priority picker. Outputs the granted mask plus the port index per grant. Parameterised by FU_NUM/RP_NUM and reusable by the RS issue select.

Test Plan (FU_NUM=4, RP_NUM=2):
- Reset, then all req_valid=1 with rsp_ready=1 continuously:
  - Cycle 1 grants {0,1}, cycle 2 grants {2,3}, cycle 3 grants {0,1}.
  - rsp_valid follows each grant by one cycle.
- Request 2 only, prs1=5 with PRF[5]=0xDEADBEEF ready:
  - prf_raddr1[0]=5 in grant cycle.
  - Next cycle rsp_valid[2]=1, rsp_rdata1[2]=0xDEADBEEF, rsp_rready1[2]=1.
- Response 1 buffered with rready2=0, prs2=9 and rsp_ready=0; wb_valid, wb_pd=9, wb_data=0x1234:
  - Next cycle rsp_rdata2[1]=0x1234, rsp_rready2[1]=1.
- FU 0 rsp held (rsp_ready=0) with req_valid=1; FUs 1, 2, 3 requesting:
  - FU 0 is not granted; ports go to 1 and 2.
  - FU 0 is granted the cycle after rsp_ready rises.
- Grants in flight, then flush_valid=1 for one cycle:
  - req_ready=0 in that cycle; all rsp_valid=0 the following cycle.
  - rr_ptr unchanged.
- Capture with prf_rready1=0 and same-cycle wb to the same prs:
  - Response shows wb_data with rready1=1.
